lut_neuron_array: RTL and testbench

- Parametrised successor to the single fixed-ROM LogicNets neuron.
- Holds NUM_NEURONS runtime-loadable truth tables, each 2^FAN_IN entries × OUT_BITS, in distributed RAM.
- Performs a registered, valid/ready-pipelined lookup for all neurons in parallel.
- Sits between quantised input features and the next layer; tables are reloaded in-system without resynthesis.

---
 rtl/lut_neuron_pkg.sv | 27 ++
 rtl/lut_neuron_array_table.sv | 31 +++
 rtl/lut_neuron_array.sv | 147 ++++++++++++++
 tb/tb_lut_neuron_array.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_neuron_pkg.sv
// Shared types and helpers for the runtime-loadable LUT neuron array.
package lut_neuron_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CFG   = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Even parity: returns the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [31:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/lut_neuron_array_table.sv
// One neuron truth table: 2^FAN_IN x W words, synchronous write, combinational read.
module lut_neuron_table #(
  parameter int FAN_IN = 6,
  parameter int W      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [FAN_IN-1:0] i_waddr,
  input  logic [W-1:0]      i_wdata,
  input  logic [FAN_IN-1:0] i_raddr,
  output logic [W-1:0]      o_rdata
);

  localparam int DEPTH = 1 << FAN_IN;

  // Tables must read back as zero after reset, so every word is cleared.
  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lut_neuron_array.sv
// Array of NUM_NEURONS loadable truth tables with a two-stage valid/ready lookup pipeline.
// Optional per-entry parity checking is enabled by defining LUT_NEURON_PARITY_EN.
module lut_neuron_array
  import lut_neuron_pkg::*;
#(
  parameter int NUM_NEURONS = 4,
  parameter int FAN_IN      = 6,
  parameter int OUT_BITS    = 1,
  parameter int NID_W       = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*FAN_IN-1:0]   in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_req,
  output logic                            cfg_ready,
  input  logic                            cfg_we,
  input  logic [NID_W-1:0]                cfg_nid,
  input  logic [FAN_IN-1:0]               cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
`ifdef LUT_NEURON_PARITY_EN
  output logic                            parity_err,
`endif
  output logic                            busy
);

`ifdef LUT_NEURON_PARITY_EN
  localparam int TBL_W = OUT_BITS + 1;
`else
  localparam int TBL_W = OUT_BITS;
`endif

  if (NID_W < clog2(NUM_NEURONS)) begin : g_nid_chk
    $error("NID_W is too narrow to address NUM_NEURONS tables");
  end

  state_e                            r_state;
  state_e                            w_state_nxt;
  logic                              r_rst_done;
  logic                              r_s1_vld;
  logic [NUM_NEURONS*FAN_IN-1:0]     r_s1_addr;
  logic                              r_s2_vld;
  logic [NUM_NEURONS*OUT_BITS-1:0]   r_s2_data;
  logic                              w_s1_adv;
  logic                              w_s2_adv;
  logic                              w_in_fire;
  logic                              w_cfg_wr;
  logic [TBL_W-1:0]                  w_wdata;
  logic [TBL_W-1:0]                  w_rd [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]            w_we;
  logic [NUM_NEURONS*OUT_BITS-1:0]   w_lookup;

  assign w_s2_adv  = !r_s2_vld || out_ready;
  assign w_s1_adv  = !r_s1_vld || w_s2_adv;
  // cfg_req blocks new words combinationally so nothing enters once a drain is requested.
  assign in_ready  = r_rst_done && (r_state == ST_RUN) && !cfg_req && w_s1_adv;
  assign w_in_fire = in_valid && in_ready;
  assign out_valid = r_s2_vld;
  assign out_data  = r_s2_data;
  assign cfg_ready = (r_state == ST_CFG);
  assign busy      = (r_state == ST_DRAIN) || (r_state == ST_CFG);
  assign w_cfg_wr  = (r_state == ST_CFG) && cfg_we;

`ifdef LUT_NEURON_PARITY_EN
  assign w_wdata = {even_parity(32'(cfg_data)), cfg_data};
`else
  assign w_wdata = cfg_data;
`endif

  // Out-of-range cfg_nid matches no table, so such writes are dropped.
  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_nrn
    assign w_we[n] = w_cfg_wr && (cfg_nid == NID_W'(n));

    lut_neuron_table #(
      .FAN_IN (FAN_IN),
      .W      (TBL_W)
    ) u_tbl (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_we[n]),
      .i_waddr (cfg_addr),
      .i_wdata (w_wdata),
      .i_raddr (r_s1_addr[n*FAN_IN +: FAN_IN]),
      .o_rdata (w_rd[n])
    );

    assign w_lookup[n*OUT_BITS +: OUT_BITS] = w_rd[n][OUT_BITS-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (cfg_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!cfg_req)                      w_state_nxt = ST_RUN;
        else if (!r_s1_vld && !r_s2_vld)   w_state_nxt = ST_CFG;
      end
      ST_CFG:   if (!cfg_req) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_rst_done <= 1'b0;
      r_s1_vld   <= 1'b0;
      r_s1_addr  <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_done <= 1'b1;
      // S1: capture accepted input word
      if (w_s1_adv) begin
        r_s1_vld <= w_in_fire;
        if (w_in_fire) r_s1_addr <= in_data;
      end
      // S2: capture table lookup of the S1 address
      if (w_s2_adv) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) r_s2_data <= w_lookup;
      end
    end
  end

`ifdef LUT_NEURON_PARITY_EN
  logic [NUM_NEURONS-1:0] w_par_bad;
  logic                   r_parity_err;

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_par
    assign w_par_bad[n] = even_parity(32'(w_rd[n]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_parity_err <= 1'b0;
    else if (w_s2_adv && r_s1_vld && |w_par_bad) r_parity_err <= 1'b1;
  end

  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_lut_neuron_array.sv
// Randomised self-checking bench for lut_neuron_array against an array/queue reference model.
module tb_lut_neuron_array;

  localparam int NN = 4;
  localparam int FI = 6;
  localparam int OB = 1;
  localparam int NW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [NN*FI-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [NN*OB-1:0]  out_data;
  logic              cfg_req;
  logic              cfg_ready;
  logic              cfg_we;
  logic [NW-1:0]     cfg_nid;
  logic [FI-1:0]     cfg_addr;
  logic [OB-1:0]     cfg_data;
  logic              busy;
`ifdef LUT_NEURON_PARITY_EN
  logic              parity_err;
`endif

  lut_neuron_array #(
    .NUM_NEURONS (NN),
    .FAN_IN      (FI),
    .OUT_BITS    (OB),
    .NID_W       (NW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_req    (cfg_req),
    .cfg_ready  (cfg_ready),
    .cfg_we     (cfg_we),
    .cfg_nid    (cfg_nid),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
`ifdef LUT_NEURON_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [OB-1:0]    mdl [NN][1<<FI];
  logic [NN*OB-1:0] exp_q [$];
  int               acc_cyc_q [$];
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               n_in = 0;
  int               n_out = 0;
  bit               last_acc;
  bit               lat_chk;
  bit               stall_pend;
  logic [NN*OB-1:0] stall_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NN*OB-1:0] predict(input logic [NN*FI-1:0] d);
    logic [NN*OB-1:0] r;
    for (int n = 0; n < NN; n++) r[n*OB +: OB] = mdl[n][d[n*FI +: FI]];
    return r;
  endfunction

  task automatic clear_model();
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < (1 << FI); a++) mdl[n][a] = '0;
    exp_q.delete();
    acc_cyc_q.delete();
    stall_pend = 0;
  endtask

  // One clock: sample handshakes just before the rising edge, return at the falling edge.
  task automatic tick();
    bit acc;
    bit ovf;
    #1;
    if (stall_pend) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(stall_data));
      stall_pend = 0;
    end
    acc = in_valid && in_ready;
    ovf = out_valid && out_ready;
    if (ovf) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q[0]));
        if (lat_chk) check("latency", cyc - acc_cyc_q[0], 32'd2);
        void'(exp_q.pop_front());
        void'(acc_cyc_q.pop_front());
        n_out++;
      end
    end
    if (out_valid && !out_ready) begin
      stall_pend = 1;
      stall_data = out_data;
    end
    if (acc) begin
      exp_q.push_back(predict(in_data));
      acc_cyc_q.push_back(cyc);
      n_in++;
    end
    last_acc = acc;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [NN*FI-1:0] d);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = d;
    last_acc = 0;
    while (!last_acc && k < 50) begin
      tick();
      k++;
    end
    in_valid = 1'b0;
    check("send_accepted", 32'(last_acc), 32'd1);
  endtask

  task automatic flush();
    int k;
    k = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && k < 50) begin
      tick();
      k++;
    end
    tick();
    check("flush_empty", exp_q.size(), 32'd0);
  endtask

  task automatic cfg_enter();
    int k;
    k = 0;
    cfg_req = 1'b1;
    while (!cfg_ready && k < 20) begin
      tick();
      k++;
    end
    check("cfg_enter", 32'(cfg_ready), 32'd1);
  endtask

  task automatic cfg_write(input int nid, input int addr, input int data, input bit honoured);
    cfg_we   = 1'b1;
    cfg_nid  = NW'(nid);
    cfg_addr = FI'(addr);
    cfg_data = OB'(data);
    if (honoured && nid < NN) mdl[nid][addr] = OB'(data);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_exit();
    cfg_req = 1'b0;
    tick();
    check("cfg_exit_busy", 32'(busy), 32'd0);
  endtask

  task automatic stream(input int nwords, input bit rand_rdy);
    int sent;
    int k;
    logic [3:0] pat;
    pat  = 4'b1001;
    sent = 0;
    k    = 0;
    in_valid = 1'b1;
    in_data  = (NN*FI)'($urandom);
    while (sent < nwords && k < 20 * nwords) begin
      out_ready = rand_rdy ? 1'($urandom) : pat[k % 4];
      tick();
      if (last_acc) begin
        sent++;
        in_data = (NN*FI)'($urandom);
      end
      k++;
    end
    in_valid = 1'b0;
    check("stream_sent", sent, nwords);
    flush();
  endtask

  initial begin
    int got;
    int a;
    logic [FI-1:0] adr;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cfg_req   = 1'b0;
    cfg_we    = 1'b0;
    cfg_nid   = '0;
    cfg_addr  = '0;
    cfg_data  = '0;
    lat_chk   = 0;
    last_acc  = 0;
    stall_data = '0;
    clear_model();

    // Reset state
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Zero tables, extreme inputs, two-cycle latency
    lat_chk   = 1;
    out_ready = 1'b1;
    send('0);
    send('1);
    flush();
    lat_chk = 0;

    // Directed load: neuron 2 @ 0x2A and neuron 0 @ 0x00
    cfg_enter();
    cfg_write(2, 'h2A, 1, 1);
    cfg_write(0, 'h00, 1, 1);
    cfg_exit();
    out_ready = 1'b1;
    send({6'h00, 6'h2A, 6'h00, 6'h00});
    out_ready = 1'b0;
    tick();
    check("directed_valid", 32'(out_valid), 32'd1);
    check("directed_0101", 32'(out_data), 32'b0101);
    flush();

    // Random tables, including writes to out-of-range neuron ids 4..7
    cfg_enter();
    cfg_write(1, 'h15, 0, 1);
    cfg_write(5, 'h15, 1, 1);
    for (int i = 0; i < 48; i++)
      cfg_write($urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 1), 1);
    cfg_exit();
    send({4{6'h15}});
    flush();

    // Streaming with out_ready 1,0,0,1 then random backpressure
    stream(8, 0);
    stream(60, 1);
    check("words_in_eq_out", n_out, n_in);

    // Drain with two words in flight and a stalled sink
    out_ready = 1'b0;
    in_valid  = 1'b1;
    got = 0;
    a = 0;
    while (got < 2 && a < 10) begin
      in_data = (NN*FI)'($urandom);
      tick();
      if (last_acc) got++;
      a++;
    end
    check("drain_two_in", got, 32'd2);
    cfg_req = 1'b1;
    adr = FI'($urandom);
    for (int i = 0; i < 4; i++) begin
      cfg_we   = 1'b1;
      cfg_nid  = '0;
      cfg_addr = adr;
      cfg_data = ~mdl[0][adr];
      tick();
      check("drain_cfg_ready", 32'(cfg_ready), 32'd0);
      check("drain_busy", 32'(busy), 32'd1);
      check("drain_in_ready", 32'(in_ready), 32'd0);
    end
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = 0;
    while (!cfg_ready && a < 20) begin
      tick();
      a++;
    end
    check("drain_to_cfg", 32'(cfg_ready), 32'd1);
    check("drain_consumed", exp_q.size(), 32'd0);
    cfg_exit();
    send({4{adr}});
    flush();

    // Reset in the middle of CFG clears tables and outputs
    cfg_enter();
    cfg_write(3, 'h3F, 1, 1);
    cfg_write(1, 'h01, 1, 1);
    rst_n   = 1'b0;
    cfg_req = 1'b0;
    #1;
    check("mid_rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    out_ready = 1'b1;
    send({6'h3F, 6'h00, 6'h01, 6'h00});
    out_ready = 1'b0;
    tick();
    check("post_rst_lookup", 32'(out_data), 32'd0);
    flush();

`ifdef LUT_NEURON_PARITY_EN
    cfg_enter();
    cfg_write(1, 'h07, 1, 1);
    cfg_exit();
    check("parity_clean", 32'(parity_err), 32'd0);
    force dut.g_nrn[1].u_tbl.r_mem[7] = 2'b01;
    send({4{6'h07}});
    flush();
    release dut.g_nrn[1].u_tbl.r_mem[7];
    check("parity_set", 32'(parity_err), 32'd1);
    repeat (3) tick();
    check("parity_sticky", 32'(parity_err), 32'd1);
    rst_n = 1'b0;
    #1;
    check("parity_rst", 32'(parity_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
